// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: nibble-serial carry-skip adder with valid/ready handshake; SKIP_STATS_EN enables skip_cnt
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             cin,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 sum,
  output logic                             cout,
  output logic                             ovf,
  output logic [$clog2(WIDTH/4+1)-1:0]     skip_cnt
);
  localparam int N  = WIDTH / 4;
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0] k;
  logic cin_q, cy, ci, c1, c2, c3, c4, nco, last, acc;
  logic [3:0] na, nb, p, g, s;
  assign acc       = in_valid & in_ready;
  assign last      = k == KW'(N - 1);
  assign ci        = (k == '0) ? cin_q : cy;
  assign na        = a_q[4*k +: 4];
  assign nb        = b_q[4*k +: 4];
  assign p         = na ^ nb;
  assign g         = na & nb;
  assign c1        = g[0] | (p[0] & ci);
  assign c2        = g[1] | (p[1] & c1);
  assign c3        = g[2] | (p[2] & c2);
  assign c4        = g[3] | (p[3] & c3);
  assign s         = p ^ {c3, c2, c1, ci};
  assign nco       = &p ? ci : c4;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = (state == IDLE) ? (acc ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // in_ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      cy       <= 1'b0;
      k        <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      in_ready <= state_nx == IDLE;
      if (acc) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
        cy    <= 1'b0;
        k     <= '0;
      end else if (state == RUN) begin
        sum[4*k +: 4] <= s;
        cy            <= nco;
        k             <= k + 1'b1;
        if (last) begin
          cout <= nco;
          ovf  <= c3 ^ nco;
        end
      end
    end
  end
`ifdef SKIP_STATS_EN
  localparam int SW = $clog2(N + 1);
  logic [SW-1:0] skips;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    skips <= '0;
    else if (acc)                  skips <= '0;
    else if (state == RUN && &p)   skips <= skips + 1'b1;
  end
  assign skip_cnt = skips;
`else
  assign skip_cnt = '0;
`endif
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized scoreboard bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;
  localparam int W  = 16;
  localparam int SW = $clog2(W/4+1);
  logic clk = 0, rst_n = 1, in_valid = 0, in_ready, cin = 0;
  logic out_valid, out_ready = 0, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [SW-1:0] skip_cnt;
  typedef struct packed {
    logic [W-1:0]  s;
    logic          co;
    logic          ov;
    logic [SW-1:0] sk;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] full;
    logic [W-1:0] d;
    int n;
    full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    d = x ^ y;
    n = 0;
    for (int i = 0; i < W/4; i++) if (d[4*i +: 4] == 4'hF) n++;
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.sk = SW'(n);
`ifndef SKIP_STATS_EN
    e.sk = '0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum %0h expected no result", sum);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
        chk("skip_cnt", 32'(skip_cnt), 32'(e.sk));
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  // mode 0: always ready, 1: random backpressure, 2: hold result 6 cycles first
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int mode);
    int t;
    logic r;
    logic [W-1:0] s0;
    logic co0, ov0;
    wait_ready();
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
      return;
    end
    in_valid = 1; a = x; b = y; cin = c;
    q.push_back(model(x, y, c));
    @(posedge clk); #1;
    t = 0;
    while (!out_valid && t < 20) begin
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      t++;
    end
    in_valid = 0;
    chk("latency", 32'(t), W/4);
    if (mode == 2) begin
      s0 = sum; co0 = cout; ov0 = ovf;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_sum", 32'(sum), 32'(s0));
        chk("hold_cout_ovf", 32'({cout, ovf}), 32'({co0, ov0}));
        chk("hold_in_ready", 32'(in_ready), 0);
      end
    end
    t = 0;
    do begin
      r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      @(posedge clk); #1;
      t++;
    end while (!r && t < 50);
    out_ready = 0;
    if (mode == 2) begin
      chk("idle_in_ready", 32'(in_ready), 1);
      chk("idle_out_valid", 32'(out_valid), 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_sum"}, 32'(sum), 0);
    chk({tag, "_cout_ovf"}, 32'({cout, ovf}), 0);
    chk({tag, "_skip_cnt"}, 32'(skip_cnt), 0);
  endtask

  initial begin
    logic [W-1:0] x, y;
    #2 rst_n = 0;
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1;
    chk("in_ready_pre_edge", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("in_ready_post_release", 32'(in_ready), 1);
    send(16'hFFFF, 16'h0001, 1'b0, 0);
    send(16'h7FFF, 16'h0001, 1'b0, 0);
    send(16'h0000, 16'h0000, 1'b1, 0);
    send(16'h8000, 16'h8000, 1'b1, 2);
    // abort two cycles into RUN; nothing is queued for this operation
    wait_ready();
    in_valid = 1; a = 16'hFFFF; b = 16'hFFFF; cin = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1 chk_zero("abort");
    @(posedge clk); #3;
    rst_n = 1;
    chk("abort_in_ready_pre_edge", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("abort_in_ready_post", 32'(in_ready), 1);
    send(16'h1234, 16'h4321, 1'b0, 0);
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if (i % 10 == 3) y = ~x;
      if (i % 10 == 7) x = {1'b0, {(W-1){1'b1}}};
      send(x, y, 1'($urandom), 1);
    end
    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
